sm_reg_dump: RTL and testbench



---
 rtl/sm_reg_dump.sv | 144 ++++++++++++++
 tb/tb_sm_reg_dump.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_reg_dump.sv
// Debug read-side master: sweeps the sm_cpu register file over its debug port and
// streams every register as a 5-byte big-endian record {addr, value[31:0]} over valid/ready.
module sm_reg_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam int CW = (READ_WAIT < 2) ? 1 : $clog2(READ_WAIT + 1);
  localparam logic [4:0]    FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0]    LAST_ADDR  = 5'(LAST_REG);
  localparam logic [CW-1:0] WAIT_LOAD  = CW'(READ_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND
  } state_t;

  state_t        r_state, w_stateNext;
  logic [CW-1:0] r_cnt, w_cntNext;
  logic [2:0]    r_byteIdx, w_byteIdxNext;
  logic [31:0]   r_shadow, w_shadowNext;
  logic [4:0]    r_regAddr, w_regAddrNext;
  logic [7:0]    r_txData, w_txDataNext;
  logic          r_txValid, w_txValidNext;
  logic          r_busy, w_busyNext;
  logic          r_done, w_doneNext;

  // Record layout: byte 0 is the register index, bytes 1..4 the snapshot MSB first.
  function automatic logic [7:0] recordByte(input logic [2:0]  idx,
                                            input logic [4:0]  addr,
                                            input logic [31:0] val);
    logic [7:0] b;
    case (idx)
      3'd1:    b = val[31:24];
      3'd2:    b = val[23:16];
      3'd3:    b = val[15:8];
      3'd4:    b = val[7:0];
      default: b = {3'b000, addr};
    endcase
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_byteIdx <= '0;
      r_shadow  <= '0;
      r_regAddr <= '0;
      r_txData  <= '0;
      r_txValid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_byteIdx <= w_byteIdxNext;
      r_shadow  <= w_shadowNext;
      r_regAddr <= w_regAddrNext;
      r_txData  <= w_txDataNext;
      r_txValid <= w_txValidNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_byteIdxNext = r_byteIdx;
    w_shadowNext  = r_shadow;
    w_regAddrNext = r_regAddr;
    w_txDataNext  = r_txData;
    w_txValidNext = r_txValid;
    w_busyNext    = r_busy;
    w_doneNext    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_regAddrNext = FIRST_ADDR;
          w_cntNext     = WAIT_LOAD;
          w_busyNext    = 1'b1;
          w_stateNext   = S_WAIT;
        end
      end

      // regAddr has been stable for READ_WAIT cycles when the counter reaches 1.
      S_WAIT: begin
        if (r_cnt == CW'(1)) begin
          w_shadowNext  = regData;
          w_txDataNext  = {3'b000, r_regAddr};
          w_txValidNext = 1'b1;
          w_byteIdxNext = 3'd0;
          w_stateNext   = S_SEND;
        end else begin
          w_cntNext = r_cnt - CW'(1);
        end
      end

      S_SEND: begin
        if (r_txValid && tx_ready) begin
          if (r_byteIdx != 3'd4) begin
            w_byteIdxNext = r_byteIdx + 3'd1;
            w_txDataNext  = recordByte(r_byteIdx + 3'd1, r_regAddr, r_shadow);
          end else if (r_regAddr == LAST_ADDR) begin
            // Terminating before the increment keeps regAddr from wrapping at 31.
            w_txValidNext = 1'b0;
            w_busyNext    = 1'b0;
            w_doneNext    = 1'b1;
            w_stateNext   = S_IDLE;
          end else begin
            w_txValidNext = 1'b0;
            w_regAddrNext = r_regAddr + 5'd1;
            w_cntNext     = WAIT_LOAD;
            w_stateNext   = S_WAIT;
          end
        end
      end

      default: w_stateNext = S_IDLE;
    endcase
  end

  assign regAddr  = r_regAddr;
  assign tx_data  = r_txData;
  assign tx_valid = r_txValid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_sm_reg_dump.sv
// Directed bench for sm_reg_dump: full sweeps, backpressure, snapshot, READ_WAIT=3,
// start during a sweep / in the done cycle, and reset mid-record.
module tb_sm_reg_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, txReady;
  int   sel;
  logic [31:0] snapData;

  logic [4:0]  addr0, addr1, addr2;
  logic [31:0] data0, data1, data2;
  logic [7:0]  txd0, txd1, txd2;
  logic        val0, val1, val2, busy0, busy1, busy2, done0, done1, done2;
  logic        start0, start1, start2;

  // Register-file models: value = index*3, a host-controlled word, and a tagged pattern.
  assign data0  = 32'(addr0) * 32'd3;
  assign data1  = snapData;
  assign data2  = 32'hA0B0_C000 | 32'(addr2);
  assign start0 = start && (sel == 0);
  assign start1 = start && (sel == 1);
  assign start2 = start && (sel == 2);

  sm_reg_dump u_def (
    .clk(clk), .rst(rst), .start(start0), .regAddr(addr0), .regData(data0),
    .tx_data(txd0), .tx_valid(val0), .tx_ready(txReady), .busy(busy0), .done(done0));

  sm_reg_dump #(.FIRST_REG(2), .LAST_REG(2), .READ_WAIT(1)) u_snap (
    .clk(clk), .rst(rst), .start(start1), .regAddr(addr1), .regData(data1),
    .tx_data(txd1), .tx_valid(val1), .tx_ready(txReady), .busy(busy1), .done(done1));

  sm_reg_dump #(.FIRST_REG(4), .LAST_REG(5), .READ_WAIT(3)) u_rw3 (
    .clk(clk), .rst(rst), .start(start2), .regAddr(addr2), .regData(data2),
    .tx_data(txd2), .tx_valid(val2), .tx_ready(txReady), .busy(busy2), .done(done2));

  logic [4:0] mAddr;
  logic [7:0] mData;
  logic       mValid, mBusy, mDone;

  always_comb begin
    mAddr = addr0; mData = txd0; mValid = val0; mBusy = busy0; mDone = done0;
    if (sel == 1) begin
      mAddr = addr1; mData = txd1; mValid = val1; mBusy = busy1; mDone = done1;
    end else if (sel == 2) begin
      mAddr = addr2; mData = txd2; mValid = val2; mBusy = busy2; mDone = done2;
    end
  end

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [7:0] expQ[$];
  int         rises[$];
  int         lastHs, doneCycle, doneCnt, holdViol, holdEvents;
  logic       busyAtDone, finished;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int s);
    sel   = s;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
  endtask

  function automatic logic [7:0] qAt(input int i);
    logic [7:0] r;
    r = (i < q.size()) ? q[i] : 8'hxx;
    return r;
  endfunction

  task automatic buildExp(input int first, input int last, input int kind);
    logic [31:0] v;
    expQ.delete();
    for (int a = first; a <= last; a++) begin
      if (kind == 0)      v = a * 3;
      else if (kind == 1) v = 32'hDEAD_BEEF;
      else                v = 32'hA0B0_C000 | a;
      expQ.push_back(8'(a));
      expQ.push_back(v[31:24]);
      expQ.push_back(v[23:16]);
      expQ.push_back(v[15:8]);
      expQ.push_back(v[7:0]);
    end
  endtask

  task automatic compareStream(input string tag);
    int bad = 0;
    checkOutput({tag, "_count"}, 32'(q.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++)
      if (qAt(i) !== expQ[i]) bad++;
    checkOutput({tag, "_byteErrors"}, 32'(bad), 32'd0);
  endtask

  // Drives tx_ready per pattern (0: always 1, 1: repeating 1,0,0,1) and logs handshakes.
  task automatic runSweep(input int pattern, input int stopAt, input int startAt,
                          input logic startOnDone, input logic changeData);
    int cyc = 0;
    int waitRun = 0;
    logic prevValid = 1'b0;
    logic prevReady = 1'b0;
    logic [7:0] prevData = 8'h00;
    logic [4:0] prevAddr = 5'd0;
    q.delete(); rises.delete();
    doneCnt = 0; holdViol = 0; holdEvents = 0; lastHs = -1; doneCycle = -1;
    busyAtDone = 1'bx; finished = 1'b0;
    while (!finished && cyc < 3000) begin
      txReady = (pattern == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      start   = (cyc == startAt);
      if (prevValid && !prevReady) begin
        holdEvents++;
        if (!(mValid && mData == prevData)) holdViol++;
      end
      if (!mValid)
        waitRun = (cyc > 0 && !prevValid && mAddr == prevAddr) ? waitRun + 1 : 1;
      else if (!prevValid)
        rises.push_back(waitRun);
      if (stopAt >= 0 && mValid && q.size() == stopAt) begin
        finished = 1'b1;
      end else begin
        if (mValid && txReady) begin
          q.push_back(mData);
          lastHs = cyc;
          if (changeData) snapData = 32'h1234_5678;
        end
        if (mDone) begin
          doneCnt++;
          doneCycle  = cyc;
          busyAtDone = mBusy;
          finished   = 1'b1;
          if (startOnDone) start = 1'b1;
        end
      end
      prevValid = mValid; prevReady = txReady; prevData = mData; prevAddr = mAddr;
      if (!finished) begin
        stepCycle();
        cyc++;
      end
    end
    checkOutput("sweepFinishedInBudget", 32'(finished), 32'd1);
  endtask

  task automatic checkDoneTiming(input string tag);
    checkOutput({tag, "_doneCycle"}, 32'(doneCycle), 32'(lastHs + 1));
    checkOutput({tag, "_busyAtDone"}, 32'(busyAtDone), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; txReady = 1'b1; sel = 0; snapData = 32'h0;
    repeat (2) stepCycle();
    checkOutput("reset_regAddr", 32'(addr0), 32'd0);
    checkOutput("reset_txData", 32'(txd0), 32'd0);
    checkOutput("reset_txValid", 32'(val0), 32'd0);
    checkOutput("reset_busy", 32'(busy0), 32'd0);
    checkOutput("reset_done", 32'(done0), 32'd0);
    rst = 1'b0;
    stepCycle();

    $display("[TB] default sweep, tx_ready=1");
    applyStimulus(0);
    checkOutput("startBusy", 32'(mBusy), 32'd1);
    checkOutput("startWaitValid", 32'(mValid), 32'd0);
    runSweep(0, -1, -1, 1'b0, 1'b0);
    buildExp(0, 31, 0);
    compareStream("defSweep");
    for (int i = 0; i < 5; i++) checkOutput("rec0", 32'(qAt(i)), 32'd0);
    checkOutput("rec5_b0", 32'(qAt(25)), 32'h05);
    checkOutput("rec5_b4", 32'(qAt(29)), 32'h0F);
    checkOutput("rec31_b0", 32'(qAt(155)), 32'h1F);
    checkOutput("rec31_b4", 32'(qAt(159)), 32'h5D);
    checkOutput("defFirstRiseWait", 32'(rises.size() > 0 ? rises[0] : -1), 32'd1);
    checkDoneTiming("defSweep");
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("doneSinglePulse", 32'(mDone), 32'd0);
    end
    checkOutput("regAddrHoldsLast", 32'(mAddr), 32'd31);

    $display("[TB] backpressure 1,0,0,1");
    applyStimulus(0);
    runSweep(1, -1, -1, 1'b0, 1'b0);
    compareStream("backpressure");
    checkOutput("holdViolations", 32'(holdViol), 32'd0);
    checkOutput("holdExercised", 32'(holdEvents > 0), 32'd1);
    checkDoneTiming("backpressure");
    txReady = 1'b1;
    stepCycle();

    $display("[TB] start mid-sweep ignored, start in done cycle restarts");
    applyStimulus(0);
    runSweep(0, -1, 50, 1'b1, 1'b0);
    compareStream("midStart");
    stepCycle();
    start = 1'b0;
    checkOutput("restartBusy", 32'(mBusy), 32'd1);
    checkOutput("restartWaitValid", 32'(mValid), 32'd0);
    stepCycle();
    checkOutput("restartValid", 32'(mValid), 32'd1);
    checkOutput("restartFirstByte", 32'(mData), 32'd0);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    stepCycle();

    $display("[TB] reset during byte2 of reg 7");
    applyStimulus(0);
    runSweep(0, 37, -1, 1'b0, 1'b0);
    checkOutput("preResetAddr", 32'(mAddr), 32'd7);
    checkOutput("preResetByte2", 32'(mData), 32'h00);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("midRst_txValid", 32'(mValid), 32'd0);
    checkOutput("midRst_busy", 32'(mBusy), 32'd0);
    checkOutput("midRst_regAddr", 32'(mAddr), 32'd0);
    checkOutput("midRst_done", 32'(mDone), 32'd0);
    doneCnt = 0;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      if (mDone) doneCnt++;
    end
    checkOutput("midRst_noDone", 32'(doneCnt), 32'd0);
    applyStimulus(0);
    runSweep(0, -1, -1, 1'b0, 1'b0);
    buildExp(0, 31, 0);
    compareStream("afterRst");
    stepCycle();

    $display("[TB] snapshot, FIRST=LAST=2");
    snapData = 32'hDEAD_BEEF;
    applyStimulus(1);
    runSweep(0, -1, -1, 1'b0, 1'b1);
    buildExp(2, 2, 1);
    compareStream("snapshot");
    checkDoneTiming("snapshot");
    stepCycle();

    $display("[TB] READ_WAIT=3, FIRST=4, LAST=5");
    applyStimulus(2);
    runSweep(0, -1, -1, 1'b0, 1'b0);
    buildExp(4, 5, 2);
    compareStream("rw3");
    checkOutput("rw3_riseCount", 32'(rises.size()), 32'd2);
    checkOutput("rw3_wait0", 32'(rises.size() > 0 ? rises[0] : -1), 32'd3);
    checkOutput("rw3_wait1", 32'(rises.size() > 1 ? rises[1] : -1), 32'd3);
    checkDoneTiming("rw3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
